// File: rtl/apb4_mem_pkg.sv
// Shared FSM encoding and byte-lane merge helper for the APB4 memory slave.
package apb4_mem_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    // Operates at the widest legal bus; callers zero-extend and truncate.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] m;
        m = old_word;
        for (int i = 0; i < MAX_SW; i++)
            if (strb[i]) m[i*8 +: 8] = new_word[i*8 +: 8];
        return m;
    endfunction

endpackage

// File: rtl/apb4_mem_array.sv
// DEPTH x DATA_W storage: async clear, one byte-enabled write port,
// one registered read port that can be forced to zero.
module apb4_mem_array
    import apb4_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strb,
    input  logic                rd_en,
    input  logic                rd_clr,
    input  logic [AW-1:0]       rd_idx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [MAX_DW-1:0] old_ext, new_ext;
    logic [MAX_SW-1:0] strb_ext;

    always_comb begin
        old_ext  = '0;
        new_ext  = '0;
        strb_ext = '0;
        old_ext[DATA_W-1:0]   = mem[wr_idx];
        new_ext[DATA_W-1:0]   = wdata;
        strb_ext[DATA_W/8-1:0] = strb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (wr_en) mem[wr_idx] <= DATA_W'(strb_merge(old_ext, new_ext, strb_ext));
            if (rd_en) rdata <= rd_clr ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 scratch RAM slave: FSM, wait-state counter, error decode, output muxing.
// Everything about a transfer is captured at setup; the bus is ignored afterwards except PSEL.
module apb4_mem_slave
    import apb4_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFS_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFS_W;
    localparam int AW     = $clog2(DEPTH);

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                wr_q, err_q;
    logic [AW-1:0]       idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                setup, commit, misalign, oor, err;
    logic [IDX_W-1:0]    idx;

    assign idx = PADDR[ADDR_W-1:OFS_W];
    assign oor = 32'(idx) >= 32'(DEPTH);

    generate
        if (OFS_W == 0) begin : g_no_ofs
            assign misalign = 1'b0;
        end else begin : g_ofs
            assign misalign = |PADDR[OFS_W-1:0];
        end
    endgenerate

    assign err = misalign | oor;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // A dropped PSEL in WAIT/ACCESS aborts silently: no commit, no error.
    always_comb begin
        state_nxt = state;
        setup     = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup     = 1'b1;
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!PSEL)            state_nxt = IDLE;
                else if (cnt == 4'd1) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = IDLE;
                commit    = PSEL && wr_q && !err_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (setup) begin
            cnt     <= 4'(WAIT_CYCLES);
            wr_q    <= PWRITE;
            err_q   <= err;
            idx_q   <= idx[AW-1:0];
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign PREADY  = (state == ACCESS);
    assign PSLVERR = err_q & PREADY;

    // Read port loads on every setup; an errored address loads zero instead.
    apb4_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .wr_en  (commit),
        .wr_idx (idx_q),
        .wdata  (wdata_q),
        .strb   (strb_q),
        .rd_en  (setup),
        .rd_clr (err),
        .rd_idx (idx[AW-1:0]),
        .rdata  (PRDATA)
    );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: three slave instances with 0, 3 and 5 wait states on a shared bus.
module tb_apb4_mem_slave;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      psel = '0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pwdata = '0;
    logic [SW-1:0]   pstrb = '0;
    logic [DW-1:0]   prdata [3];
    logic            pready [3];
    logic            pslverr [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb4_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_CYCLES(5)) u_w5 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Setup cycle, then access phase until PREADY (bounded); n = access-phase cycles.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [SW-1:0] st,
                        output logic [DW-1:0] rd, output logic er, output int n);
        @(negedge clk);
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable = 1'b1;
        n = 1;
        while (!pready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        rd = prdata[d];
        er = pslverr[d];
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel = '0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            n, t0;
        logic [DW-1:0] exp_b2b [4];
        logic [AW-1:0] adr_b2b [4];

        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_prdata", prdata[i], 0);
            chk("rst_pready", pready[i], 0);
            chk("rst_pslverr", pslverr[i], 0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait write then immediately read back
        xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, rd, er, n);
        chk("w0_wr_len", n, 1);
        chk("w0_wr_err", er, 0);
        xfer(0, 0, 12'h010, 32'h0, 4'h0, rd, er, n);
        chk("w0_rd_len", n, 1);
        chk("w0_rd_data", rd, 32'hDEADBEEF);
        chk("w0_rd_err", er, 0);

        // Byte strobes, including an all-zero strobe
        xfer(0, 1, 12'h020, 32'h11223344, 4'hF, rd, er, n);
        xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, er, n);
        xfer(0, 0, 12'h020, 32'h0, 4'hF, rd, er, n);
        chk("strb_merge", rd, 32'h11BB33DD);
        xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0, rd, er, n);
        chk("strb0_err", er, 0);
        xfer(0, 0, 12'h020, 32'h0, 4'h0, rd, er, n);
        chk("strb0_data", rd, 32'h11BB33DD);

        // Out-of-range write (would alias idx 0 if truncated) and misaligned read
        xfer(0, 1, 12'h000, 32'h5A5A5A5A, 4'hF, rd, er, n);
        xfer(0, 1, 12'h400, 32'hFFFFFFFF, 4'hF, rd, er, n);
        chk("oor_wr_len", n, 1);
        chk("oor_wr_err", er, 1);
        xfer(0, 0, 12'h012, 32'h0, 4'hF, rd, er, n);
        chk("mis_rd_err", er, 1);
        chk("mis_rd_data", rd, 0);
        xfer(0, 0, 12'h000, 32'h0, 4'hF, rd, er, n);
        chk("oor_mem_keep", rd, 32'h5A5A5A5A);
        chk("ok_rd_err", er, 0);
        bus_idle();

        // Three wait states: ready timing, late bus changes ignored, commit on exit edge
        xfer(1, 0, 12'h010, 32'h0, 4'h0, rd, er, n);
        chk("w3_rd_len", n, 4);
        chk("w3_rd_data", rd, 0);
        @(negedge clk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010;
        pwdata = 32'hCAFEBABE; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        pwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("w3_wait_rdy", pready[1], 0);
            chk("w3_wait_mem", u_w3.u_mem.mem[4], 0);
            @(negedge clk);
        end
        chk("w3_acc_rdy", pready[1], 1);
        chk("w3_acc_mem", u_w3.u_mem.mem[4], 0);
        @(negedge clk);
        psel = '0; penable = 1'b0;
        chk("w3_commit_mem", u_w3.u_mem.mem[4], 32'hCAFEBABE);
        xfer(1, 0, 12'h010, 32'h0, 4'h0, rd, er, n);
        chk("w3_rdback", rd, 32'hCAFEBABE);
        bus_idle();

        // Four back-to-back reads
        adr_b2b = '{12'h010, 12'h014, 12'h010, 12'h000};
        exp_b2b = '{32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 32'h0};
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 0, adr_b2b[i], 32'h0, 4'h0, rd, er, n);
            chk("b2b_data", rd, exp_b2b[i]);
        end
        chk("b2b_cycles", cyc - t0, 4 * (3 + 2));
        bus_idle();

        // Write aborted by PSEL drop during WAIT
        @(negedge clk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010;
        pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = '0; penable = 1'b0;
        @(negedge clk);
        chk("abort_rdy", pready[1], 0);
        repeat (4) @(negedge clk);
        xfer(1, 0, 12'h010, 32'h0, 4'h0, rd, er, n);
        chk("abort_mem_keep", rd, 32'hCAFEBABE);
        chk("abort_rd_err", er, 0);
        bus_idle();

        // Reset in the 2nd wait cycle of a five-wait write
        xfer(2, 1, 12'h008, 32'hCAFEF00D, 4'hF, rd, er, n);
        chk("w5_wr_len", n, 6);
        @(negedge clk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("w5_setup_prdata", prdata[2], 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prdata", prdata[2], 0);
        chk("mid_rst_pready", pready[2], 0);
        chk("mid_rst_pslverr", pslverr[2], 0);
        psel = '0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(2, 0, 12'h008, 32'h0, 4'h0, rd, er, n);
        chk("post_rst_len", n, 6);
        chk("post_rst_data", rd, 0);
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 memory-mapped slave: byte-addressed, word-organised storage with per-byte write strobes, configurable wait states and error response. It replaces the fixed 32-bit/256-entry zero-wait slave on the peripheral bus. It serves as the generic scratch/config RAM behind the APB interconnect.

## Interface
- DATA_W, 32, data width; legal values 8/16/32/64
- ADDR_W, 12, byte-address width; must be ≥ clog2(DEPTH)+clog2(DATA_W/8)
- DEPTH, 256, number of DATA_W words
- WAIT_CYCLES, 0, PREADY-low cycles inserted in every access phase (0..15)
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  byte-lane write enables
- PRDATA  out  DATA_W  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only with PREADY

## Operation
- Constants: STRB_W=DATA_W/8, OFS_W=clog2(STRB_W), word index idx=PADDR[ADDR_W-1:OFS_W].
- Error conditions, evaluated in setup: PADDR[OFS_W-1:0]≠0 (misaligned) or idx ≥ DEPTH (out of range).
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: PSEL&!PENABLE (setup) → latch PWRITE, idx, err, PWDATA, PSTRB; load cnt=WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: cnt decrements each cycle; at cnt==1 go to ACCESS.
  - ACCESS: PREADY=1; at the edge go to IDLE.
  - If PSEL is low in WAIT/ACCESS (master abort): go to IDLE, no write, no error.
- Read: at the setup edge PRDATA ← mem[idx], or 0 if err. It holds until the next setup edge.
- Write: commits on the ACCESS-exit edge when err=0. Only lanes with PSTRB[i]=1 update byte i. PSTRB=0 is a legal no-op with no error.
- Errored writes leave memory untouched. Errored reads return PRDATA=0.
- PSTRB is ignored for reads.
- PSLVERR = err_q & PREADY; it is 0 in all other cycles.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, all memory words 0.
- Access-phase length is exactly WAIT_CYCLES+1 cycles. PREADY is combinational from state and high only in the final cycle.
- Back-to-back transfers: a setup in the cycle after ACCESS is accepted from IDLE, giving zero bus idle.
- A new write is visible to a read whose setup is in the cycle after the write's ACCESS.
- Reset mid-transfer (any state): immediate return to reset values; the in-flight write is discarded.
- PRDATA, PWDATA and PSTRB are sampled/registered once per transfer. Bus changes during WAIT are ignored apart from PSEL (abort).

## Structure
- Package apb4_mem_pkg holds:
  - typedef enum state_t {IDLE, WAIT, ACCESS}
  - function strb_merge(old, new, strb), returning the byte-lane merge
- Sub-module apb4_mem_array: DEPTH×DATA_W storage with async clear, one byte-enabled write port, one registered read port.
- The top level holds the FSM, wait counter, error decode and output muxing.

## Test plan
1. DATA_W=32, WAIT_CYCLES=0:
   - Stimulus: write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010.
   - Response: PREADY high in the first access cycle of each transfer; read returns 0xDEADBEEF; PSLVERR=0.
2. Strobes:
   - Stimulus: write 0x11223344 to 0x020 with PSTRB=0xF; write 0xAABBCCDD to 0x020 with PSTRB=0b0101; read 0x020.
   - Response: read returns 0x11BB33DD.
3. WAIT_CYCLES=3:
   - Stimulus: one read and one write.
   - Response: PREADY low for 3 access cycles and high on the 4th; memory updates only after the 4th.
4. Errors:
   - Stimulus: write to 0x400 (idx 256, DEPTH=256); read from 0x012 (misaligned).
   - Response: PSLVERR=1 with PREADY on both; memory unchanged; PRDATA=0.
5. Reset during WAIT (WAIT_CYCLES=5):
   - Stimulus: start a write of 0x12345678 to 0x008; drop PRESETn on the 2nd wait cycle.
   - Response: outputs return to 0 immediately; a read of 0x008 after reset returns 0.
6. Back-to-back and abort:
   - Stimulus: 4 consecutive reads with no idle cycle; then a write with PSEL dropped during WAIT.
   - Response: all 4 reads complete in 4×(WAIT_CYCLES+2) cycles; the aborted write leaves memory unchanged.
